// File: rtl/tlb_op_sequencer.sv
// TLB operation sequencer: runs TLBP / TLBR / TLBWI / TLBWR against the CAM
// array, owns the Random register, and stalls lookups while an op is in flight.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for Op_Req; lookups unstalled
// PROBE  | port B borrowed for the latched EntryHi, match vector encoded
// READ   | latched entry contents captured into Read_Data
// WRITE  | one-hot write strobe to the latched entry
// DONE   | Op_Ack pulse; still stalled so no lookup sees a fresh write early
module tlb_op_sequencer #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  Op_Req,
  input  logic [1:0]            Op_Code,
  output logic                  Op_Ack,
  output logic                  Busy,
  output logic                  Lookup_Stall,
  input  logic [IDX_W-1:0]      Index_In,
  input  logic [IDX_W-1:0]      Wired_In,
  input  logic                  Wired_Write,
  output logic [IDX_W-1:0]      Random_Out,
  input  logic [26:0]           EntryHi_In,
  input  logic [15:0]           PageMask_In,
  input  logic                  G_In,
  output logic [IDX_W-1:0]      Probe_Index,
  output logic                  Probe_Miss,
  output logic [43:0]           Read_Data,
  input  logic [19:0]           D_VPN,
  input  logic [7:0]            D_ASID,
  output logic [19:0]           Cam_VPN_B,
  output logic [7:0]            Cam_ASID_B,
  input  logic [ENTRIES-1:0]    Cam_Match_B,
  output logic [43:0]           Cam_Data_In,
  output logic [ENTRIES-1:0]    Cam_Write,
  input  logic [ENTRIES*44-1:0] Cam_Data_Out
);

  localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(ENTRIES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PROBE = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx_q;
  logic [43:0]        data_q;
  logic [IDX_W-1:0]   hit_idx;
  logic               hit;
  logic               accept;

  assign accept      = (state == S_IDLE) && Op_Req;
  assign Cam_Data_In = data_q;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode and combinational outputs; Cam_Write is decoded from
  // state so an asynchronous reset removes the strobe immediately.
  always_comb begin
    state_nxt    = state;
    Op_Ack       = 1'b0;
    Busy         = 1'b0;
    Lookup_Stall = 1'b0;
    Cam_Write    = '0;
    Cam_VPN_B    = D_VPN;
    Cam_ASID_B   = D_ASID;
    case (state)
      S_IDLE: begin
        if (Op_Req) begin
          case (Op_Code)
            2'b00:   state_nxt = S_PROBE;
            2'b01:   state_nxt = S_READ;
            default: state_nxt = S_WRITE;
          endcase
        end
      end
      S_PROBE: begin
        Busy         = 1'b1;
        Lookup_Stall = 1'b1;
        Cam_VPN_B    = {data_q[43:25], 1'b0};
        Cam_ASID_B   = data_q[8:1];
        state_nxt    = S_DONE;
      end
      S_READ: begin
        Busy         = 1'b1;
        Lookup_Stall = 1'b1;
        state_nxt    = S_DONE;
      end
      S_WRITE: begin
        Busy         = 1'b1;
        Lookup_Stall = 1'b1;
        Cam_Write    = {{(ENTRIES-1){1'b0}}, 1'b1} << idx_q;
        state_nxt    = S_DONE;
      end
      S_DONE: begin
        Busy         = 1'b1;
        Lookup_Stall = 1'b1;
        Op_Ack       = 1'b1;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture target index and packed entry data at accept; TLBWR takes the
  // Random value of the accept cycle, before any Wired_Write reload lands.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      idx_q  <= (Op_Code == 2'b11) ? Random_Out : Index_In;
      data_q <= {EntryHi_In[26:8], PageMask_In, EntryHi_In[7:0], G_In};
    end
  end

  // Lowest matching entry wins.
  always_comb begin
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (Cam_Match_B[i]) hit_idx = IDX_W'(i);
    end
  end

  assign hit = |Cam_Match_B;

  // Probe and read results, held until the next op of the same kind.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      Probe_Index <= '0;
      Probe_Miss  <= 1'b0;
      Read_Data   <= '0;
    end else begin
      if (state == S_PROBE) begin
        Probe_Index <= hit ? hit_idx : '0;
        Probe_Miss  <= ~hit;
      end
      if (state == S_READ) begin
        Read_Data <= Cam_Data_Out[int'(idx_q) * 44 +: 44];
      end
    end
  end

  // Random counts down every clock, wrapping to the top at or below Wired.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                Random_Out <= RAND_TOP;
    else if (Wired_Write || Random_Out <= Wired_In) Random_Out <= RAND_TOP;
    else                                         Random_Out <= Random_Out - IDX_ONE;
  end

endmodule
